vga_write_arbiter: RTL

- Shares the single VGA adapter write port (x, y, colour, plot) among three drawing requesters: tower placer (square/tower draw and erase), enemy sprite drawer, and background restorer.
- Grants whole drawing operations, not single pixels, so one requester's square or tower is never interleaved with another's pixels.
- Round-robin fairness and a hold watchdog keep any one requester from starving the others.
- Sits between the drawing FSM/datapath pairs and the vga_adapter instance.

---
 rtl/vga_write_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: hands the shared VGA adapter write port to one of three drawing
// requesters for a whole operation, in round-robin order, with a hold watchdog.
//
// state   | meaning
// ST_IDLE | no owner; arbitrate among pending requests (one turnaround cycle)
// ST_OWN  | owner_q holds the port; its pixels are registered to the adapter
module vga_write_arbiter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int MAX_HOLD = 20000,
    parameter int HOLD_W   = 15
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_0,
    input  logic                req_1,
    input  logic                req_2,
    input  logic                rel_0,
    input  logic                rel_1,
    input  logic                rel_2,
    input  logic [X_W-1:0]      x_0,
    input  logic [X_W-1:0]      x_1,
    input  logic [X_W-1:0]      x_2,
    input  logic [Y_W-1:0]      y_0,
    input  logic [Y_W-1:0]      y_1,
    input  logic [Y_W-1:0]      y_2,
    input  logic [COLOUR_W-1:0] colour_0,
    input  logic [COLOUR_W-1:0] colour_1,
    input  logic [COLOUR_W-1:0] colour_2,
    input  logic                plot_0,
    input  logic                plot_1,
    input  logic                plot_2,
    output logic                gnt_0,
    output logic                gnt_1,
    output logic                gnt_2,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                timeout
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic                state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                timeout_q, timeout_d;

    logic [2:0] req_v;
    assign req_v = {req_2, req_1, req_0};

    logic                own_req, own_rel, own_plot;
    logic [X_W-1:0]      own_x;
    logic [Y_W-1:0]      own_y;
    logic [COLOUR_W-1:0] own_colour;

    always_comb begin
        own_req    = 1'b0;
        own_rel    = 1'b0;
        own_plot   = 1'b0;
        own_x      = '0;
        own_y      = '0;
        own_colour = '0;
        case (owner_q)
            2'd0: begin
                own_req = req_0; own_rel = rel_0; own_plot = plot_0;
                own_x = x_0; own_y = y_0; own_colour = colour_0;
            end
            2'd1: begin
                own_req = req_1; own_rel = rel_1; own_plot = plot_1;
                own_x = x_1; own_y = y_1; own_colour = colour_1;
            end
            2'd2: begin
                own_req = req_2; own_rel = rel_2; own_plot = plot_2;
                own_x = x_2; own_y = y_2; own_colour = colour_2;
            end
            default: ;
        endcase
    end

    // Rotate requests so bit 0 is the requester right after the last owner.
    logic [2:0] req_rot;
    always_comb begin
        case (last_q)
            2'd0:    req_rot = {req_v[0], req_v[2], req_v[1]};
            2'd1:    req_rot = {req_v[1], req_v[0], req_v[2]};
            default: req_rot = req_v;
        endcase
    end

    logic [1:0] pos;
    logic [2:0] pick_sum;
    logic [1:0] pick;
    logic       pick_vld;

    always_comb begin
        if (req_rot[0])      pos = 2'd0;
        else if (req_rot[1]) pos = 2'd1;
        else                 pos = 2'd2;
        pick_vld = |req_rot;
        pick_sum = {1'b0, last_q} + 3'd1 + {1'b0, pos};
        pick     = (pick_sum >= 3'd3) ? 2'(pick_sum - 3'd3) : pick_sum[1:0];
    end

    logic fin;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        timeout_d = timeout_q;
        fin       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d      = ST_OWN;
                    owner_d      = pick;
                    hold_d       = '0;
                    gnt_d        = 3'b000;
                    gnt_d[pick]  = 1'b1;
                end
            end
            ST_OWN: begin
                x_d      = own_x;
                y_d      = own_y;
                colour_d = own_colour;
                // Release takes precedence over both a dropped request and the watchdog.
                if (own_rel) begin
                    plot_d = own_plot;
                    fin    = 1'b1;
                end else if (!own_req) begin
                    fin = 1'b1;
                end else begin
                    plot_d = own_plot;
                    if (hold_q == HOLD_LAST) begin
                        timeout_d = 1'b1;
                        fin       = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                if (fin) begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd2;
            hold_q    <= '0;
            gnt_q     <= 3'b000;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_0      = gnt_q[0];
    assign gnt_1      = gnt_q[1];
    assign gnt_2      = gnt_q[2];
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign busy       = |gnt_q;
    assign timeout    = timeout_q;

endmodule
